// File: rtl/anita_trig_pkg.sv
// Shared encodings and default widths for the ANITA PPS / external trigger inputs.
// Warm-up length is the number of post-reset cycles edge detection stays masked.
package anita_trig_pkg;

    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_sel_e;

    localparam int PPS_HOLD_W = 8;
    localparam int PPS_CNT_W  = 16;

    localparam logic [1:0] WARM_LEN = 2'd3;

endpackage

// File: rtl/anita_pps_trig_chan.sv
// One trigger channel: 2-flop synchroniser, selectable edge, holdoff, fired/suppressed counters.
// Latency: input sampled at edge k -> chan_trig high after edge k+2; no backpressure, counters saturate.
module anita_pps_trig_chan
    import anita_trig_pkg::*;
#(
    parameter int HOLD_W = PPS_HOLD_W,
    parameter int CNT_W  = PPS_CNT_W
) (
    input  logic              clk33_i,
    input  logic              rst_n_i,
    input  logic              warm,
    input  logic              pps,
    input  logic              en,
    input  logic              edge_sel,
    input  logic              hold_dis,
    input  logic [HOLD_W-1:0] holdoff_len,
    input  logic              cnt_clr,
    output logic              chan_trig,
    output logic              holdoff,
    output logic [CNT_W-1:0]  fired_cnt,
    output logic [CNT_W-1:0]  supp_cnt
);

    logic              s1, s2, prv;
    logic [HOLD_W-1:0] hcnt;
    logic              edge_det;
    logic              fire;
    logic              suppress;

    always_comb begin
        edge_det = 1'b0;
        if (warm) begin
            edge_det = (edge_sel == EDGE_FALL) ? (prv & ~s2) : (s2 & ~prv);
        end
        fire     = edge_det & en & (hcnt == '0);
        suppress = edge_det & en & (hcnt != '0);
    end

    assign holdoff = (hcnt != '0);

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            prv       <= 1'b0;
            chan_trig <= 1'b0;
        end else begin
            s1        <= pps;
            s2        <= s1;
            prv       <= s2;
            chan_trig <= fire;
        end
    end

    // Arm on the same edge that registers the pulse, so the counter reads L
    // while the pulse is visible and the next pulse can land L+1 cycles later.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hcnt <= '0;
        end else if (fire && !hold_dis && (holdoff_len != '0)) begin
            hcnt <= holdoff_len;
        end else if (hcnt != '0) begin
            hcnt <= hcnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fired_cnt <= '0;
            supp_cnt  <= '0;
        end else if (cnt_clr) begin
            fired_cnt <= '0;
            supp_cnt  <= '0;
        end else begin
            if (fire && (fired_cnt != '1)) begin
                fired_cnt <= fired_cnt + CNT_W'(1);
            end
            if (suppress && (supp_cnt != '1)) begin
                supp_cnt <= supp_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/anita_multi_pps_trigger.sv
// NCH-channel PPS/external trigger with post-reset warm-up mask and merged OR output.
// Latency: 2 cycles from first sample to chan_trig_o, trig_o same cycle; no backpressure.
module anita_multi_pps_trigger
    import anita_trig_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int HOLD_W = PPS_HOLD_W,
    parameter int CNT_W  = PPS_CNT_W
) (
    input  logic                 clk33_i,
    input  logic                 rst_n_i,
    input  logic [NCH-1:0]       pps_i,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH-1:0]       edge_sel_i,
    input  logic                 disable_i,
    input  logic [HOLD_W-1:0]    holdoff_len_i,
    input  logic                 cnt_clr_i,
    output logic [NCH-1:0]       chan_trig_o,
    output logic                 trig_o,
    output logic [NCH-1:0]       holdoff_o,
    output logic [NCH*CNT_W-1:0] fired_cnt_o,
    output logic [NCH*CNT_W-1:0] supp_cnt_o
);

    logic [1:0] warm_cnt;
    logic       warm;

    // Masks the synchroniser fill so an input already high at release never fires.
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            warm_cnt <= '0;
        end else if (warm_cnt != WARM_LEN) begin
            warm_cnt <= warm_cnt + 2'd1;
        end
    end

    assign warm = (warm_cnt == WARM_LEN);

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        anita_pps_trig_chan #(
            .HOLD_W (HOLD_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk33_i     (clk33_i),
            .rst_n_i     (rst_n_i),
            .warm        (warm),
            .pps         (pps_i[g]),
            .en          (en_i[g]),
            .edge_sel    (edge_sel_i[g]),
            .hold_dis    (disable_i),
            .holdoff_len (holdoff_len_i),
            .cnt_clr     (cnt_clr_i),
            .chan_trig   (chan_trig_o[g]),
            .holdoff     (holdoff_o[g]),
            .fired_cnt   (fired_cnt_o[g*CNT_W +: CNT_W]),
            .supp_cnt    (supp_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    assign trig_o = |chan_trig_o;

endmodule

// File: tb/tb_anita_multi_pps_trigger.sv
// Bench for anita_multi_pps_trigger: edge-history model with holdoff windows,
// plus directed scenarios with literal expectations. Small CNT_W so saturation is reachable.
module tb_anita_multi_pps_trigger;

    localparam int NCH    = 2;
    localparam int HOLD_W = 8;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NCH-1:0]       pps = '0;
    logic [NCH-1:0]       en = '0;
    logic [NCH-1:0]       edge_sel = '0;
    logic                 dis = 1'b0;
    logic [HOLD_W-1:0]    hl = '0;
    logic                 clr = 1'b0;
    logic [NCH-1:0]       chan_trig;
    logic                 trig;
    logic [NCH-1:0]       holdoff;
    logic [NCH*CNT_W-1:0] fired_flat;
    logic [NCH*CNT_W-1:0] supp_flat;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    anita_multi_pps_trigger #(
        .NCH    (NCH),
        .HOLD_W (HOLD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk33_i       (clk),
        .rst_n_i       (rst_n),
        .pps_i         (pps),
        .en_i          (en),
        .edge_sel_i    (edge_sel),
        .disable_i     (dis),
        .holdoff_len_i (hl),
        .cnt_clr_i     (clr),
        .chan_trig_o   (chan_trig),
        .trig_o        (trig),
        .holdoff_o     (holdoff),
        .fired_cnt_o   (fired_flat),
        .supp_cnt_o    (supp_flat)
    );

    always #15 clk = ~clk;

    function automatic int fired_of(input int c);
        return int'(fired_flat[c*CNT_W +: CNT_W]);
    endfunction

    function automatic int supp_of(input int c);
        return int'(supp_flat[c*CNT_W +: CNT_W]);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Model: every rising clock edge n after reset release appends the sampled
    // input; a pulse after edge n reflects the transition between samples n-3
    // and n-2 (masked for n<4). A trigger at edge t with length L blocks
    // edges t+1..t+L; holdoff is reported while n < t+L.
    bit             hist_q[NCH][$];
    int             n_edge;
    int             until_e[NCH];
    int             fired_m[NCH];
    int             supp_m[NCH];
    logic [NCH-1:0] exp_trig = '0;
    logic [NCH-1:0] exp_hold = '0;

    initial begin
        bit a, b, det, blocked, fire;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                n_edge = 0;
                for (int c = 0; c < NCH; c++) begin
                    hist_q[c].delete();
                    hist_q[c].push_back(1'b0);
                    until_e[c] = 0;
                    fired_m[c] = 0;
                    supp_m[c]  = 0;
                end
                exp_trig = '0;
                exp_hold = '0;
            end else begin
                n_edge = n_edge + 1;
                for (int c = 0; c < NCH; c++) begin
                    hist_q[c].push_back(pps[c]);
                    det = 1'b0;
                    if (n_edge >= 4) begin
                        a   = hist_q[c][n_edge-3];
                        b   = hist_q[c][n_edge-2];
                        det = edge_sel[c] ? (a && !b) : (!a && b);
                    end
                    blocked = (n_edge <= until_e[c]);
                    fire    = det && en[c] && !blocked;
                    if (clr) begin
                        fired_m[c] = 0;
                        supp_m[c]  = 0;
                    end else begin
                        if (fire && fired_m[c] < CMAX) fired_m[c]++;
                        if (det && en[c] && blocked && supp_m[c] < CMAX) supp_m[c]++;
                    end
                    if (fire && !dis && hl != '0) until_e[c] = n_edge + int'(hl);
                    exp_trig[c] = fire;
                    exp_hold[c] = (n_edge < until_e[c]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("m_chan_trig", int'(chan_trig), int'(exp_trig));
                check("m_trig", int'(trig), int'(|exp_trig));
                check("m_holdoff", int'(holdoff), int'(exp_hold));
                for (int c = 0; c < NCH; c++) begin
                    check($sformatf("m_fired%0d", c), fired_of(c), fired_m[c]);
                    check($sformatf("m_supp%0d", c), supp_of(c), supp_m[c]);
                end
            end
        end
    end

    initial begin
        int hcount;

        pps      = 2'b01;
        en       = 2'b11;
        edge_sel = 2'b00;
        hl       = 8'd10;
        #2 rst_n = 1'b0;
        #1 mon_en = 1'b1;

        // Reset with ch0 already high, then warm-up mask.
        repeat (3) tick();
        check("rst_chan_trig", int'(chan_trig), 0);
        check("rst_holdoff", int'(holdoff), 0);
        check("rst_fired0", fired_of(0), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("warm_mask", int'(chan_trig), 0);
        end
        pps[0] = 1'b0;
        repeat (4) tick();

        // Rising edge latency, merged output, holdoff length.
        pps[0] = 1'b1;
        tick();
        tick();
        check("lat_k1", int'(chan_trig[0]), 0);
        tick();
        check("lat_k2", int'(chan_trig[0]), 1);
        check("lat_trig_o", int'(trig), 1);
        check("lat_fired", fired_of(0), 1);
        hcount = holdoff[0] ? 1 : 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i <= 10 && holdoff[0]) hcount++;
            if (i == 5) begin
                check("hold_block", int'(chan_trig[0]), 0);
                check("hold_supp", supp_of(0), 1);
            end
            if (i == 10) check("hold_end", int'(holdoff[0]), 0);
            if (i == 11) begin
                check("hold_refire", int'(chan_trig[0]), 1);
                check("hold_fired2", fired_of(0), 2);
            end
            if (i == 1) pps[0] = 1'b0;
            if (i == 2) pps[0] = 1'b1;
            if (i == 4) pps[0] = 1'b0;
            if (i == 8) pps[0] = 1'b1;
        end
        check("hold_len", hcount, 10);
        pps[0] = 1'b0;
        repeat (12) tick();

        // Disable during the trigger cycle: no holdoff, quick refire.
        dis    = 1'b1;
        pps[0] = 1'b1;
        tick();
        pps[0] = 1'b0;
        tick();
        tick();
        check("dis_fire", int'(chan_trig[0]), 1);
        check("dis_nohold", int'(holdoff[0]), 0);
        dis    = 1'b0;
        pps[0] = 1'b1;
        tick();
        tick();
        pps[0] = 1'b0;
        tick();
        check("dis_refire", int'(chan_trig[0]), 1);
        repeat (12) tick();

        // Opposite polarities on both channels, then polarity toggling alone.
        hl       = 8'd0;
        edge_sel = 2'b10;
        pps      = 2'b11;
        repeat (3) tick();
        check("dual_rise", int'(chan_trig), 1);
        pps = 2'b00;
        repeat (3) tick();
        check("dual_fall", int'(chan_trig), 2);
        tick();
        tick();
        edge_sel = 2'b01;
        tick();
        edge_sel = 2'b11;
        tick();
        edge_sel = 2'b00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("sel_toggle", int'(chan_trig), 0);
        end

        // Saturation of fired counter, then clear coincident with a trigger.
        for (int i = 0; i < 20; i++) begin
            pps[0] = 1'b1;
            tick();
            tick();
            pps[0] = 1'b0;
            tick();
            tick();
        end
        repeat (3) tick();
        check("fired_sat", fired_of(0), 15);
        check("fired1", fired_of(1), 1);
        pps[0] = 1'b1;
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_trig", int'(chan_trig[0]), 1);
        check("clr_wins", fired_of(0), 0);

        // Disabling a channel keeps its holdoff and does not count suppressions.
        hl     = 8'd10;
        pps[0] = 1'b0;
        tick();
        tick();
        pps[0] = 1'b1;
        repeat (3) tick();
        check("en_fire", int'(chan_trig[0]), 1);
        en     = 2'b10;
        pps[0] = 1'b0;
        tick();
        tick();
        pps[0] = 1'b1;
        repeat (4) tick();
        check("en_off_trig", int'(chan_trig[0]), 0);
        check("en_off_supp", supp_of(0), 0);
        check("en_off_hold", int'(holdoff[0]), 1);
        en     = 2'b11;
        pps[0] = 1'b0;
        repeat (12) tick();

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/anita_multi_pps_trigger.md
Name: anita_multi_pps_trigger

Overview:
Parametrised successor to the single-channel 33 MHz PPS trigger. It takes NCH asynchronous pulse sources (GPS PPS A/B, external trigger inputs) and treats each identically: synchroniser, selectable edge polarity, per-channel enable and programmable holdoff. Each channel produces a 1-cycle trigger pulse, and the block also produces a merged trigger. It keeps saturating fired/suppressed counters for housekeeping readout, and sits between the front-panel/GPS inputs and the TURF trigger merger.

Parameters:
NCH, 2, number of input channels (1..8)
HOLD_W, 8, width of holdoff length; max holdoff 2^HOLD_W-1 cycles
CNT_W, 16, width of per-channel fired/suppressed counters

Ports:
clk33_i  in  1  system clock, 33 MHz
rst_n_i  in  1  reset, asynchronous assert, active-low
pps_i  in  NCH  raw asynchronous pulse inputs
en_i  in  NCH  per-channel trigger enable
edge_sel_i  in  NCH  0 = rising edge, 1 = falling edge
disable_i  in  1  when high in a trigger cycle, holdoff is not armed
holdoff_len_i  in  HOLD_W  holdoff length in cycles, shared by all channels; 0 = none
cnt_clr_i  in  1  synchronous clear of all counters
chan_trig_o  out  NCH  per-channel 1-cycle trigger pulse (registered)
trig_o  out  1  OR of chan_trig_o
holdoff_o  out  NCH  per-channel holdoff active
fired_cnt_o  out  NCH*CNT_W  triggers issued per channel; channel i at [i*CNT_W +: CNT_W]
supp_cnt_o  out  NCH*CNT_W  edges suppressed by holdoff while enabled, same packing

Behaviour:
- Reset: all flops go to 0 while rst_n_i is low. All outputs are 0 during reset.
- Warm-up: a 2-bit counter counts to 3 after reset release. Edge detection is masked until it saturates, so an input already high at reset release never fires.
- Per-channel sync: s1 <= pps_i[i]; s2 <= s1; prv <= s2.
- Edge: edge = warm & (edge_sel ? (prv & ~s2) : (s2 & ~prv)).
- Trigger: chan_trig <= edge & en_i[i] & (hcnt == 0).
- Latency: input first sampled in its new state at edge k gives chan_trig_o high after edge k+2, for exactly one cycle.
- Holdoff counter hcnt (HOLD_W bits):
  - if chan_trig=1, disable_i=0 and holdoff_len_i != 0: hcnt <= holdoff_len_i
  - else if hcnt != 0: hcnt <= hcnt-1
- holdoff_o[i] = (hcnt != 0).
- Holdoff timing: a trigger in cycle t blocks triggers whose registered pulse would fall in t+1..t+L. The earliest next trigger is cycle t+L+1.
- Holdoff edge cases:
  - Changing holdoff_len_i mid-holdoff has no effect until the next arm.
  - disable_i going high mid-holdoff does not cancel the holdoff.
  - With L=0, retriggering is limited only by edge spacing (minimum 2 cycles).
- Suppression: edge & en_i[i] & (hcnt != 0) increments supp_cnt. Edges with en_i[i]=0 are not counted.
- Counters: saturate at all-ones. When cnt_clr_i and an increment coincide, the clear wins and the result is 0.
- Polarity change: toggling edge_sel_i never fires by itself; a trigger still needs a real transition.
- en_i deasserting does not clear an active holdoff.
- Merged output: trig_o = |chan_trig_o, combinational from registered bits. There is no extra latency and no priority; simultaneous channels all show in chan_trig_o.

Decomposition:
- Shared package anita_trig_pkg:
  - edge-select encodings EDGE_RISE=0 and EDGE_FALL=1
  - default widths PPS_HOLD_W=8 and PPS_CNT_W=16
  - warm-up length constant = 3
- Natural sub-module: anita_pps_trig_chan, one channel (sync, edge, holdoff, two counters). The top generates NCH instances, plus the warm-up counter and the OR.

Test Plan:
- Reset held, pps_i[0] high; release reset -> chan_trig_o stays 0 for 20 cycles (warm-up mask).
- en=1, rising, L=10; pps_i[0] 0->1 sampled at edge k -> chan_trig_o[0]=1 only in cycle k+2; trig_o=1 same cycle; fired_cnt[0]=1; holdoff_o[0] high 10 cycles.
- L=10; second rising edge with trigger slot at t+5 -> no trigger, supp_cnt=1. Edge with trigger slot at t+11 -> fires, fired_cnt=2.
- disable_i=1 during trigger cycle, L=10 -> holdoff_o stays 0; an edge 3 cycles later fires.
- edge_sel=1 on ch1, both channels toggled together -> ch0 fires on rise, ch1 fires on fall. Toggling edge_sel with a static input -> no trigger.
- Force fired_cnt to saturate (CNT_W=4 build): 20 edges -> holds 15. Assert cnt_clr_i coincident with a trigger -> counter reads 0 next cycle.
